// File: rtl/iq_pkg.sv
// Shared types, defaults and helpers for the integer issue queue.
// Entry fields are sized by IQ_TAG_W / IQ_PAYLOAD_W; the queue's TAG_W and
// PAYLOAD_W parameters must equal them. The wakeup helper takes vectors
// zero-extended to IQ_WKP_MAX buses.
package iq_pkg;

    localparam int unsigned IQ_DEPTH       = 8;
    localparam int unsigned IQ_ENQ_PORTS   = 2;
    localparam int unsigned IQ_ISSUE_PORTS = 2;
    localparam int unsigned IQ_WKP_PORTS   = 3;
    localparam int unsigned IQ_TAG_W       = 6;
    localparam int unsigned IQ_PAYLOAD_W   = 12;
    localparam int unsigned IQ_WKP_MAX     = 8;
    localparam int unsigned IQ_WKP_VEC_W   = IQ_WKP_MAX * IQ_TAG_W;

    typedef struct packed {
        logic                    valid;
        logic [IQ_PAYLOAD_W-1:0] payload;
        logic [IQ_TAG_W-1:0]     rs1_tag;
        logic [IQ_TAG_W-1:0]     rs2_tag;
        logic                    rs1_rdy;
        logic                    rs2_rdy;
    } iq_entry_t;

    // True when any valid wakeup bus carries the given tag.
    function automatic logic wkp_match(
        input logic [IQ_TAG_W-1:0]     tag,
        input logic [IQ_WKP_MAX-1:0]   vld,
        input logic [IQ_WKP_VEC_W-1:0] tags
    );
        logic hit;
        hit = 1'b0;
        for (int unsigned w = 0; w < IQ_WKP_MAX; w++) begin
            if (vld[w] && (tags[w*IQ_TAG_W +: IQ_TAG_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/iq_pick.sv
// Multi-port oldest-first picker. i_age[j][i] = 1 means entry j is older
// than entry i; the diagonal must be zero. Each port takes the oldest
// remaining eligible entry, which is then masked out for later ports.
module iq_pick
    import iq_pkg::*;
#(
    parameter int unsigned DEPTH       = IQ_DEPTH,
    parameter int unsigned ISSUE_PORTS = IQ_ISSUE_PORTS
) (
    input  logic [DEPTH-1:0]                  i_elig,
    input  logic [DEPTH-1:0][DEPTH-1:0]       i_age,
    output logic [ISSUE_PORTS-1:0][DEPTH-1:0] o_gnt
);

    // Iterative masking: grant the unblocked entry, then remove it.
    always_comb begin
        logic [DEPTH-1:0] rem;
        logic             blk;
        rem   = i_elig;
        blk   = 1'b0;
        o_gnt = '0;
        for (int unsigned p = 0; p < ISSUE_PORTS; p++) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                blk = 1'b0;
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    if (rem[j] && i_age[j][i]) blk = 1'b1;
                end
                o_gnt[p][i] = rem[i] & ~blk;
            end
            rem = rem & ~o_gnt[p];
        end
    end

endmodule

// File: rtl/int_issue_queue.sv
// Unified integer issue queue: entries wait for both sources to be ready and
// issue oldest-first to ISSUE_PORTS execute ports.
// Build option IQ_AGE_ORDER_EN: keep an age matrix for true oldest-first
// selection; without it selection is lowest-index-first.
module int_issue_queue
    import iq_pkg::*;
#(
    parameter int unsigned DEPTH       = IQ_DEPTH,
    parameter int unsigned ENQ_PORTS   = IQ_ENQ_PORTS,
    parameter int unsigned ISSUE_PORTS = IQ_ISSUE_PORTS,
    parameter int unsigned WKP_PORTS   = IQ_WKP_PORTS,
    parameter int unsigned TAG_W       = IQ_TAG_W,
    parameter int unsigned PAYLOAD_W   = IQ_PAYLOAD_W
) (
    input  logic                             cpu_clock_i,
    input  logic                             cpu_reset_i,
    input  logic                             flush_i,
    input  logic [ENQ_PORTS-1:0]             enq_vld_i,
    input  logic [ENQ_PORTS*PAYLOAD_W-1:0]   enq_payload_i,
    input  logic [ENQ_PORTS*TAG_W-1:0]       enq_rs1_tag_i,
    input  logic [ENQ_PORTS*TAG_W-1:0]       enq_rs2_tag_i,
    input  logic [ENQ_PORTS-1:0]             enq_rs1_vld_i,
    input  logic [ENQ_PORTS-1:0]             enq_rs2_vld_i,
    input  logic [ENQ_PORTS-1:0]             enq_rs1_rdy_i,
    input  logic [ENQ_PORTS-1:0]             enq_rs2_rdy_i,
    output logic                             busy_o,
    input  logic [WKP_PORTS-1:0]             wkp_vld_i,
    input  logic [WKP_PORTS*TAG_W-1:0]       wkp_tag_i,
    output logic [ISSUE_PORTS-1:0]           iss_vld_o,
    output logic [ISSUE_PORTS*PAYLOAD_W-1:0] iss_payload_o,
    output logic [ISSUE_PORTS*TAG_W-1:0]     iss_rs1_tag_o,
    output logic [ISSUE_PORTS*TAG_W-1:0]     iss_rs2_tag_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    iq_entry_t                        r_ent     [DEPTH];
    iq_entry_t                        w_ent_nxt [DEPTH];
    iq_entry_t                        w_new     [ENQ_PORTS];
    logic [DEPTH-1:0]                 w_valid;
    logic [DEPTH-1:0]                 w_elig;
    logic [DEPTH-1:0]                 w_alloc_any;
    logic [ENQ_PORTS-1:0][DEPTH-1:0]  w_alloc;
    logic [ISSUE_PORTS-1:0][DEPTH-1:0] w_gnt;
    logic [DEPTH-1:0][DEPTH-1:0]      w_age;
    logic [CNT_W-1:0]                 w_free_cnt;
    logic [IQ_WKP_MAX-1:0]            w_wkp_vld;
    logic [IQ_WKP_VEC_W-1:0]          w_wkp_tag;

    assign w_wkp_vld = IQ_WKP_MAX'(wkp_vld_i);
    assign w_wkp_tag = IQ_WKP_VEC_W'(wkp_tag_i);

    // Per-entry valid and issue eligibility from registered state.
    always_comb begin
        w_valid = '0;
        w_elig  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_valid[i] = r_ent[i].valid;
            w_elig[i]  = r_ent[i].valid & r_ent[i].rs1_rdy & r_ent[i].rs2_rdy;
        end
    end

    // Busy from registered occupancy only; same-cycle frees are not counted.
    always_comb begin
        w_free_cnt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!w_valid[i]) w_free_cnt = w_free_cnt + CNT_W'(1);
        end
    end
    assign busy_o = (w_free_cnt < CNT_W'(ENQ_PORTS));

    // Valid slots take the lowest free indices in slot order.
    always_comb begin
        logic [DEPTH-1:0] rem;
        logic             found;
        rem         = ~w_valid;
        found       = 1'b0;
        w_alloc     = '0;
        w_alloc_any = '0;
        for (int unsigned k = 0; k < ENQ_PORTS; k++) begin
            found = 1'b0;
            if (enq_vld_i[k] && !busy_o) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (rem[i] && !found) begin
                        w_alloc[k][i] = 1'b1;
                        found         = 1'b1;
                    end
                end
            end
            rem         = rem & ~w_alloc[k];
            w_alloc_any = w_alloc_any | w_alloc[k];
        end
    end

    // New entries, with ready bits bypassing a same-cycle wakeup.
    always_comb begin
        for (int unsigned k = 0; k < ENQ_PORTS; k++) begin
            w_new[k].valid   = 1'b1;
            w_new[k].payload = IQ_PAYLOAD_W'(enq_payload_i[k*PAYLOAD_W +: PAYLOAD_W]);
            w_new[k].rs1_tag = IQ_TAG_W'(enq_rs1_tag_i[k*TAG_W +: TAG_W]);
            w_new[k].rs2_tag = IQ_TAG_W'(enq_rs2_tag_i[k*TAG_W +: TAG_W]);
            w_new[k].rs1_rdy = !enq_rs1_vld_i[k] || enq_rs1_rdy_i[k] ||
                               wkp_match(w_new[k].rs1_tag, w_wkp_vld, w_wkp_tag);
            w_new[k].rs2_rdy = !enq_rs2_vld_i[k] || enq_rs2_rdy_i[k] ||
                               wkp_match(w_new[k].rs2_tag, w_wkp_vld, w_wkp_tag);
        end
    end

    // Entry update: free on issue, otherwise wake up, or load on allocation.
    always_comb begin
        logic [DEPTH-1:0] issued;
        issued = '0;
        for (int unsigned p = 0; p < ISSUE_PORTS; p++) issued = issued | w_gnt[p];
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_ent_nxt[i] = r_ent[i];
            if (issued[i]) begin
                w_ent_nxt[i].valid = 1'b0;
            end else if (w_valid[i]) begin
                if (wkp_match(r_ent[i].rs1_tag, w_wkp_vld, w_wkp_tag)) w_ent_nxt[i].rs1_rdy = 1'b1;
                if (wkp_match(r_ent[i].rs2_tag, w_wkp_vld, w_wkp_tag)) w_ent_nxt[i].rs2_rdy = 1'b1;
            end
            for (int unsigned k = 0; k < ENQ_PORTS; k++) begin
                if (w_alloc[k][i]) w_ent_nxt[i] = w_new[k];
            end
        end
    end

    // Entry storage; reset and flush clear every entry.
    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i || flush_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_ent[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) r_ent[i] <= w_ent_nxt[i];
        end
    end

`ifdef IQ_AGE_ORDER_EN
    logic [DEPTH-1:0][DEPTH-1:0] r_age;
    logic [DEPTH-1:0][DEPTH-1:0] w_age_nxt;

    // A new entry is younger than all others; earlier slots beat later ones.
    always_comb begin
        w_age_nxt = r_age;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            for (int unsigned c = 0; c < DEPTH; c++) begin
                if (r == c) begin
                    w_age_nxt[r][c] = 1'b0;
                end else if (w_alloc_any[c]) begin
                    w_age_nxt[r][c] = 1'b1;
                    for (int unsigned kr = 0; kr < ENQ_PORTS; kr++) begin
                        for (int unsigned kc = 0; kc < ENQ_PORTS; kc++) begin
                            if (w_alloc[kr][r] && w_alloc[kc][c]) w_age_nxt[r][c] = (kr < kc);
                        end
                    end
                end else if (w_alloc_any[r]) begin
                    w_age_nxt[r][c] = 1'b0;
                end
            end
        end
    end

    // Age matrix register.
    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i || flush_i) r_age <= '0;
        else                        r_age <= w_age_nxt;
    end

    assign w_age = r_age;
`else
    // Fixed priority: a lower index always counts as older.
    always_comb begin
        w_age = '0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            for (int unsigned c = 0; c < DEPTH; c++) w_age[r][c] = (r < c);
        end
    end
`endif

    iq_pick #(
        .DEPTH       (DEPTH),
        .ISSUE_PORTS (ISSUE_PORTS)
    ) u_pick (
        .i_elig (w_elig),
        .i_age  (w_age),
        .o_gnt  (w_gnt)
    );

    // Issue registers: copy granted entry per port, zero when unfilled.
    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i || flush_i) begin
            iss_vld_o     <= '0;
            iss_payload_o <= '0;
            iss_rs1_tag_o <= '0;
            iss_rs2_tag_o <= '0;
        end else begin
            for (int unsigned p = 0; p < ISSUE_PORTS; p++) begin
                iss_vld_o[p]                          <= |w_gnt[p];
                iss_payload_o[p*PAYLOAD_W +: PAYLOAD_W] <= '0;
                iss_rs1_tag_o[p*TAG_W +: TAG_W]         <= '0;
                iss_rs2_tag_o[p*TAG_W +: TAG_W]         <= '0;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (w_gnt[p][i]) begin
                        iss_payload_o[p*PAYLOAD_W +: PAYLOAD_W] <= PAYLOAD_W'(r_ent[i].payload);
                        iss_rs1_tag_o[p*TAG_W +: TAG_W]         <= TAG_W'(r_ent[i].rs1_tag);
                        iss_rs2_tag_o[p*TAG_W +: TAG_W]         <= TAG_W'(r_ent[i].rs2_tag);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_int_issue_queue.sv
// Directed self-checking bench for int_issue_queue (default 8/2/2/3 config).
module tb_int_issue_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned ENQ   = 2;
    localparam int unsigned ISS   = 2;
    localparam int unsigned WKP   = 3;
    localparam int unsigned TW    = 6;
    localparam int unsigned PW    = 12;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic [ENQ-1:0]     enq_vld;
    logic [ENQ*PW-1:0]  enq_payload;
    logic [ENQ*TW-1:0]  enq_rs1_tag, enq_rs2_tag;
    logic [ENQ-1:0]     enq_rs1_vld, enq_rs2_vld, enq_rs1_rdy, enq_rs2_rdy;
    logic               busy;
    logic [WKP-1:0]     wkp_vld;
    logic [WKP*TW-1:0]  wkp_tag;
    logic [ISS-1:0]     iss_vld;
    logic [ISS*PW-1:0]  iss_payload;
    logic [ISS*TW-1:0]  iss_rs1_tag, iss_rs2_tag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    int_issue_queue #(
        .DEPTH(DEPTH), .ENQ_PORTS(ENQ), .ISSUE_PORTS(ISS),
        .WKP_PORTS(WKP), .TAG_W(TW), .PAYLOAD_W(PW)
    ) dut (
        .cpu_clock_i   (clk),
        .cpu_reset_i   (rst),
        .flush_i       (flush),
        .enq_vld_i     (enq_vld),
        .enq_payload_i (enq_payload),
        .enq_rs1_tag_i (enq_rs1_tag),
        .enq_rs2_tag_i (enq_rs2_tag),
        .enq_rs1_vld_i (enq_rs1_vld),
        .enq_rs2_vld_i (enq_rs2_vld),
        .enq_rs1_rdy_i (enq_rs1_rdy),
        .enq_rs2_rdy_i (enq_rs2_rdy),
        .busy_o        (busy),
        .wkp_vld_i     (wkp_vld),
        .wkp_tag_i     (wkp_tag),
        .iss_vld_o     (iss_vld),
        .iss_payload_o (iss_payload),
        .iss_rs1_tag_o (iss_rs1_tag),
        .iss_rs2_tag_o (iss_rs2_tag)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush       = 1'b0;
        enq_vld     = '0;
        enq_payload = '0;
        enq_rs1_tag = '0;
        enq_rs2_tag = '0;
        enq_rs1_vld = '0;
        enq_rs2_vld = '0;
        enq_rs1_rdy = '0;
        enq_rs2_rdy = '0;
        wkp_vld     = '0;
        wkp_tag     = '0;
    endtask

    task automatic set_enq(input int k, input logic [PW-1:0] pl,
                           input logic r1v, input logic [TW-1:0] t1, input logic r1r,
                           input logic r2v, input logic [TW-1:0] t2, input logic r2r);
        enq_vld[k]               = 1'b1;
        enq_payload[k*PW +: PW]  = pl;
        enq_rs1_vld[k]           = r1v;
        enq_rs1_tag[k*TW +: TW]  = t1;
        enq_rs1_rdy[k]           = r1r;
        enq_rs2_vld[k]           = r2v;
        enq_rs2_tag[k*TW +: TW]  = t2;
        enq_rs2_rdy[k]           = r2r;
    endtask

    task automatic set_wkp(input int w, input logic [TW-1:0] t);
        wkp_vld[w]           = 1'b1;
        wkp_tag[w*TW +: TW]  = t;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        checks++;
        if (iss_vld !== 2'b00) begin errors++; $display("FAIL reset_iss_vld got %b exp 00", iss_vld); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++;
        if (iss_payload !== '0 || iss_rs1_tag !== '0) begin
            errors++; $display("FAIL reset_fields got pl=%h t1=%h exp 0", iss_payload, iss_rs1_tag);
        end
        rst = 1'b0;
    endtask

    task automatic test_dual_issue();
        set_enq(0, 12'h011, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
        set_enq(1, 12'h022, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
        step();
        idle_inputs();
        checks++;
        if (iss_vld !== 2'b00) begin errors++; $display("FAIL dual_early got %b exp 00", iss_vld); end
        step();
        checks++;
        if (iss_vld !== 2'b11) begin errors++; $display("FAIL dual_vld got %b exp 11", iss_vld); end
        checks++;
        if (iss_payload[0 +: PW] !== 12'h011 || iss_payload[PW +: PW] !== 12'h022) begin
            errors++; $display("FAIL dual_payload got p0=%h p1=%h exp 011 022", iss_payload[0 +: PW], iss_payload[PW +: PW]);
        end
        step();
        checks++;
        if (iss_vld !== 2'b00) begin errors++; $display("FAIL dual_reissue got %b exp 00", iss_vld); end
    endtask

    task automatic test_wakeup();
        set_enq(0, 12'h033, 1'b1, 6'd9, 1'b0, 1'b0, 6'd0, 1'b0);
        step();
        idle_inputs();
        checks++;
        if (iss_vld !== 2'b00) begin errors++; $display("FAIL wake_wait1 got %b exp 00", iss_vld); end
        step();
        checks++;
        if (iss_vld !== 2'b00) begin errors++; $display("FAIL wake_wait2 got %b exp 00", iss_vld); end
        set_wkp(2, 6'd9);
        step();
        idle_inputs();
        checks++;
        if (iss_vld !== 2'b00) begin errors++; $display("FAIL wake_early got %b exp 00", iss_vld); end
        step();
        checks++;
        if (iss_vld !== 2'b01 || iss_payload[0 +: PW] !== 12'h033 || iss_rs1_tag[0 +: TW] !== 6'd9) begin
            errors++; $display("FAIL wake_issue got vld=%b pl=%h t1=%0d exp 01 033 9", iss_vld, iss_payload[0 +: PW], iss_rs1_tag[0 +: TW]);
        end
        step();
        checks++;
        if (iss_vld !== 2'b00) begin errors++; $display("FAIL wake_after got %b exp 00", iss_vld); end
    endtask

    task automatic test_bypass();
        set_enq(0, 12'h044, 1'b1, 6'd12, 1'b0, 1'b1, 6'd13, 1'b1);
        set_wkp(0, 6'd12);
        step();
        idle_inputs();
        checks++;
        if (iss_vld !== 2'b00) begin errors++; $display("FAIL bypass_early got %b exp 00", iss_vld); end
        step();
        checks++;
        if (iss_vld !== 2'b01 || iss_payload[0 +: PW] !== 12'h044 || iss_rs2_tag[0 +: TW] !== 6'd13) begin
            errors++; $display("FAIL bypass_issue got vld=%b pl=%h t2=%0d exp 01 044 13", iss_vld, iss_payload[0 +: PW], iss_rs2_tag[0 +: TW]);
        end
    endtask

    task automatic test_full();
        do_flush();
        for (int p = 0; p < 3; p++) begin
            set_enq(0, 12'(12'h100 + 2*p),     1'b1, 6'(40 + 2*p), 1'b0, 1'b0, 6'd0, 1'b0);
            set_enq(1, 12'(12'h100 + 2*p + 1), 1'b1, 6'(41 + 2*p), 1'b0, 1'b0, 6'd0, 1'b0);
            step();
            idle_inputs();
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL full_six_busy got %b exp 0", busy); end
        set_enq(0, 12'h106, 1'b1, 6'd46, 1'b0, 1'b0, 6'd0, 1'b0);
        step();
        idle_inputs();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL full_seven_busy got %b exp 1", busy); end
        set_enq(0, 12'h0EE, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
        set_enq(1, 12'h0EF, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
        step();
        idle_inputs();
        checks++;
        if (busy !== 1'b1 || iss_vld !== 2'b00) begin
            errors++; $display("FAIL full_drop1 got busy=%b vld=%b exp 1 00", busy, iss_vld);
        end
        step();
        checks++;
        if (iss_vld !== 2'b00) begin errors++; $display("FAIL full_drop2 got %b exp 00", iss_vld); end
        set_wkp(1, 6'd43);
        step();
        idle_inputs();
        checks++;
        if (busy !== 1'b1 || iss_vld !== 2'b00) begin
            errors++; $display("FAIL full_wake got busy=%b vld=%b exp 1 00", busy, iss_vld);
        end
        step();
        checks++;
        if (iss_vld !== 2'b01 || iss_payload[0 +: PW] !== 12'h103 || busy !== 1'b0) begin
            errors++; $display("FAIL full_free got vld=%b pl=%h busy=%b exp 01 103 0", iss_vld, iss_payload[0 +: PW], busy);
        end
        // back-to-back reuse of the freed entry
        set_enq(0, 12'h0AB, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
        step();
        idle_inputs();
        checks++;
        if (busy !== 1'b1 || iss_vld !== 2'b00) begin
            errors++; $display("FAIL b2b_enq got busy=%b vld=%b exp 1 00", busy, iss_vld);
        end
        step();
        checks++;
        if (iss_vld !== 2'b01 || iss_payload[0 +: PW] !== 12'h0AB || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_issue got vld=%b pl=%h busy=%b exp 01 0ab 0", iss_vld, iss_payload[0 +: PW], busy);
        end
    endtask

    task automatic test_age_order();
        logic [PW-1:0] exp0, exp1;
`ifdef IQ_AGE_ORDER_EN
        exp0 = 12'h0AA;
        exp1 = 12'h0BB;
`else
        exp0 = 12'h0BB;
        exp1 = 12'h0AA;
`endif
        do_flush();
        set_enq(0, 12'h0C0, 1'b1, 6'd20, 1'b0, 1'b0, 6'd0, 1'b0);
        set_enq(1, 12'h0C1, 1'b1, 6'd21, 1'b0, 1'b0, 6'd0, 1'b0);
        step(); idle_inputs();
        set_enq(0, 12'h0C2, 1'b1, 6'd22, 1'b0, 1'b0, 6'd0, 1'b0);
        set_enq(1, 12'h0C3, 1'b1, 6'd23, 1'b0, 1'b0, 6'd0, 1'b0);
        step(); idle_inputs();
        set_enq(0, 12'h0C4, 1'b1, 6'd24, 1'b0, 1'b0, 6'd0, 1'b0);
        set_enq(1, 12'h0AA, 1'b1, 6'd30, 1'b0, 1'b0, 6'd0, 1'b0);
        step(); idle_inputs();
        set_wkp(0, 6'd20);
        step(); idle_inputs();
        step();
        checks++;
        if (iss_vld !== 2'b01 || iss_payload[0 +: PW] !== 12'h0C0) begin
            errors++; $display("FAIL age_free0 got vld=%b pl=%h exp 01 0c0", iss_vld, iss_payload[0 +: PW]);
        end
        set_enq(0, 12'h0BB, 1'b1, 6'd30, 1'b0, 1'b0, 6'd0, 1'b0);
        step(); idle_inputs();
        set_wkp(0, 6'd30);
        step(); idle_inputs();
        checks++;
        if (iss_vld !== 2'b00) begin errors++; $display("FAIL age_early got %b exp 00", iss_vld); end
        step();
        checks++;
        if (iss_vld !== 2'b11 || iss_payload[0 +: PW] !== exp0 || iss_payload[PW +: PW] !== exp1) begin
            errors++; $display("FAIL age_order got vld=%b p0=%h p1=%h exp 11 %h %h",
                               iss_vld, iss_payload[0 +: PW], iss_payload[PW +: PW], exp0, exp1);
        end
    endtask

    task automatic test_flush();
        do_flush();
        set_enq(0, 12'h150, 1'b1, 6'd50, 1'b0, 1'b0, 6'd0, 1'b0);
        set_enq(1, 12'h151, 1'b0, 6'd0,  1'b0, 1'b0, 6'd0, 1'b0);
        step(); idle_inputs();
        flush = 1'b1;
        set_enq(0, 12'h152, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
        set_wkp(0, 6'd50);
        step(); idle_inputs();
        checks++;
        if (iss_vld !== 2'b00 || busy !== 1'b0) begin
            errors++; $display("FAIL flush_now got vld=%b busy=%b exp 00 0", iss_vld, busy);
        end
        checks++;
        if (iss_payload !== '0 || iss_rs1_tag !== '0) begin
            errors++; $display("FAIL flush_fields got pl=%h t1=%h exp 0", iss_payload, iss_rs1_tag);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (iss_vld !== 2'b00) begin
                errors++; $display("FAIL flush_stale cycle %0d got %b pl=%h exp 00", c, iss_vld, iss_payload);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_dual_issue();
        test_wakeup();
        test_bypass();
        test_full();
        test_age_order();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
